// File: rtl/v_bank_mem_responder.sv
// Four-bank vector data-memory responder: handshaked store/load bursts of 128-bit beats over 4x32-bit banks.
// Lane rotation for misaligned addresses is built only when VBANK_UNALIGNED_EN is defined.

module v_bank_mem_bank #(
  parameter int DEPTH = 4096,
  parameter int RW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [RW-1:0] row,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[row] <= wdata;

  // Output register holds its value between reads so a stalled beat stays stable.
  always_ff @(posedge clk or posedge rst)
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[row];
endmodule

module v_bank_mem_responder #(
  parameter int BANK_DEPTH = 4096,
  parameter int ADDR_W     = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_beats,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [127:0]      wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [127:0]      rd_data,
  output logic              done,
  output logic              err
);
  localparam int RW = $clog2(BANK_DEPTH);

  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_RSP, DONE, ERR} state_t;
  state_t state, state_nx;

  logic [ADDR_W-3:0]   row_base;
  logic [2:0]          beats_q;
  logic [1:0]          b;
  logic                accept, illegal, last;
  logic                bank_we, bank_re;
  logic [RW-1:0]       r0;
  logic [3:0][31:0]    wr_lane, bank_wd, bank_q, rd_lane;
  logic [3:0][RW-1:0]  bank_row;

  assign accept  = req_valid && req_ready;
  assign last    = ({1'b0, b} == beats_q - 3'd1);
  assign r0      = RW'(row_base);
  assign wr_lane = wr_data;
  assign bank_we = (state == WR) && wr_valid;
  assign bank_re = (state == RD_REQ);

`ifdef VBANK_UNALIGNED_EN
  logic [1:0] k;

  always_ff @(posedge clk or posedge rst)
    if (rst)         k <= '0;
    else if (accept) k <= req_addr[1:0];

  assign illegal = (req_beats == 3'd0) || (req_beats > 3'd4);
`else
  assign illegal = (req_beats == 3'd0) || (req_beats > 3'd4) || (req_addr[1:0] != 2'd0);
`endif

  for (genvar j = 0; j < 4; j++) begin : g_bank
`ifdef VBANK_UNALIGNED_EN
    // Banks below the start bank hold the wrapped lanes and sit one row further on.
    assign bank_row[j] = r0 + RW'(b) + RW'(2'(j) < k);
    assign bank_wd[j]  = wr_lane[2'(j) - k];
    assign rd_lane[j]  = bank_q[2'(j) + k];
`else
    assign bank_row[j] = r0 + RW'(b);
    assign bank_wd[j]  = wr_lane[j];
    assign rd_lane[j]  = bank_q[j];
`endif
    v_bank_mem_bank #(.DEPTH(BANK_DEPTH), .RW(RW)) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (bank_we),
      .re    (bank_re),
      .row   (bank_row[j]),
      .wdata (bank_wd[j]),
      .rdata (bank_q[j])
    );
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      b        <= '0;
      row_base <= '0;
      beats_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        row_base <= req_addr[ADDR_W-1:2];
        beats_q  <= req_beats;
        b        <= '0;
      end else if (bank_we || (state == RD_RSP && rd_ready && !last)) begin
        b <= b + 2'd1;
      end
    end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = '0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (accept) state_nx = illegal ? ERR : (req_write ? WR : RD_REQ);
      end
      WR: begin
        wr_ready = 1'b1;
        if (wr_valid && last) state_nx = DONE;
      end
      RD_REQ: state_nx = RD_RSP;
      RD_RSP: begin
        rd_valid = 1'b1;
        rd_data  = rd_lane;
        if (rd_ready) state_nx = last ? DONE : RD_REQ;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      ERR: begin
        err      = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_v_bank_mem_responder.sv
// Scoreboard bench for v_bank_mem_responder: stimulus queues expected beats/events, a negedge monitor checks them.
module tb_v_bank_mem_responder;
  logic         clk = 0, rst = 1;
  logic         req_valid = 0, req_write = 0;
  logic [13:0]  req_addr = '0;
  logic [2:0]   req_beats = '0;
  logic         wr_valid = 0, rd_ready = 1;
  logic [127:0] wr_data = '0;
  logic         req_ready, wr_ready, rd_valid, done, err;
  logic [127:0] rd_data;

  int errors = 0, checks = 0;
  logic [127:0] rd_q[$];
  int           ev_q[$];   // 0 = done, 1 = err
  logic [127:0] sbuf[4], lbuf[4];

  v_bank_mem_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_beats(req_beats), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected want event", name);
  endtask

  // Monitor: pops expected beats and done/err tokens whenever the DUT presents them.
  always @(negedge clk) if (!rst) begin
    if (done && err) fail_now("done_err_both");
    if (rd_valid && rd_ready) begin
      if (rd_q.size() == 0) fail_now("rd_unexpected");
      else check("rd_beat", rd_data, rd_q.pop_front());
    end
    if (done || err) begin
      if (ev_q.size() == 0) fail_now("event_unexpected");
      else check("event_kind", {127'd0, err}, 128'(ev_q.pop_front()));
      if (done) check("done_after_last_beat", 128'(rd_q.size()), 128'd0);
    end
  end

  task automatic request(input bit w, input logic [13:0] a, input logic [2:0] n);
    int t = 0;
    @(posedge clk); #1;
    req_valid = 1; req_write = w; req_addr = a; req_beats = n;
    @(negedge clk);
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    if (!req_ready) fail_now("req_ready_wait");
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    if (!req_ready) fail_now("idle_wait");
  endtask

  task automatic wait_rd_valid();
    int t = 0;
    @(negedge clk);
    while (!rd_valid && t < 20) begin @(negedge clk); t++; end
    if (!rd_valid) fail_now("rd_valid_wait");
  endtask

  // Stores sbuf[0..n-1]; stops after stop_at handshakes (leaving the burst open) when stop_at < n.
  task automatic store(input logic [13:0] a, input logic [2:0] n, input int stop_at, input bit exp_err);
    int t;
    if (exp_err) ev_q.push_back(1);
    else if (stop_at >= int'(n)) ev_q.push_back(0);
    if (exp_err) begin
      wr_valid = 1; wr_data = '1;
    end
    request(1, a, n);
    if (exp_err) begin
      @(negedge clk); check("err_req_ready_c1", 128'(req_ready), 128'd0);
      @(negedge clk); check("err_req_ready_c2", 128'(req_ready), 128'd1);
      wr_valid = 0;
      return;
    end
    wr_valid = 1;
    for (int i = 0; i < int'(n) && i < stop_at; i++) begin
      wr_data = sbuf[i];
      t = 0;
      @(negedge clk);
      while (!wr_ready && t < 20) begin @(negedge clk); t++; end
      if (!wr_ready) fail_now("wr_ready_wait");
      @(posedge clk); #1;
    end
    wr_valid = 0;
    if (stop_at >= int'(n)) wait_idle();
  endtask

  task automatic load(input logic [13:0] a, input logic [2:0] n, input bit chk_lat);
    for (int i = 0; i < int'(n); i++) rd_q.push_back(lbuf[i]);
    ev_q.push_back(0);
    request(0, a, n);
    if (chk_lat) begin
      @(negedge clk); check("load_lat_c1", 128'(rd_valid), 128'd0);
      @(negedge clk); check("load_lat_c2", 128'(rd_valid), 128'd1);
    end
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 128'(req_ready), 128'd0);
    check({tag, "_wr_ready"},  128'(wr_ready),  128'd0);
    check({tag, "_rd_valid"},  128'(rd_valid),  128'd0);
    check({tag, "_rd_data"},   rd_data,         128'd0);
    check({tag, "_done"},      128'(done),      128'd0);
    check({tag, "_err"},       128'(err),       128'd0);
  endtask

  localparam logic [127:0] A0 = 128'h33333333_22222222_11111111_00000000;
  localparam logic [127:0] A1 = 128'h77777777_66666666_55555555_44444444;
  localparam logic [127:0] M  = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

  initial begin
    logic [13:0] wrap_a;
    @(negedge clk); @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1 rst = 0;
    @(negedge clk); check("rst_release_req_ready", 128'(req_ready), 128'd1);

    // Aligned store then load with latency check.
    sbuf[0] = A0; sbuf[1] = A1;
    store(14'h010, 3'd2, 4, 0);
    lbuf[0] = A0; lbuf[1] = A1;
    load(14'h010, 3'd2, 1);

    // Illegal beat counts with live write data: no access, memory unchanged.
    store(14'h010, 3'd0, 4, 1);
    store(14'h010, 3'd5, 4, 1);
    load(14'h010, 3'd2, 0);

    // Misaligned store.
    sbuf[0] = M;
`ifdef VBANK_UNALIGNED_EN
    store(14'h013, 3'd1, 4, 0);
    lbuf[0] = M;
    load(14'h013, 3'd1, 0);
    lbuf[0] = 128'hAAAAAAAA_22222222_11111111_00000000;
    lbuf[1] = 128'h77777777_DDDDDDDD_CCCCCCCC_BBBBBBBB;
    load(14'h010, 3'd2, 0);
    wrap_a = 14'h3FFE;
`else
    store(14'h013, 3'd1, 4, 1);
    load(14'h010, 3'd2, 0);
    wrap_a = 14'h3FFC;
`endif

    // Backpressure: 3-beat load, beat 1 stalled for 5 cycles.
    sbuf[0] = 128'h0B000003_0B000002_0B000001_0B000000;
    sbuf[1] = 128'h1B000003_1B000002_1B000001_1B000000;
    sbuf[2] = 128'h2B000003_2B000002_2B000001_2B000000;
    store(14'h040, 3'd3, 4, 0);
    for (int i = 0; i < 3; i++) rd_q.push_back(sbuf[i]);
    ev_q.push_back(0);
    rd_ready = 1;
    request(0, 14'h040, 3'd3);
    wait_rd_valid();
    @(posedge clk); #1 rd_ready = 0;
    wait_rd_valid();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid_held", 128'(rd_valid), 128'd1);
      check("bp_data_stable", rd_data, sbuf[1]);
    end
    @(posedge clk); #1 rd_ready = 1;
    wait_idle();

    // Reset mid-store: prior contents P, then abort a 4-beat store after 2 beats.
    for (int i = 0; i < 4; i++) sbuf[i] = {4{32'h50000000 + 32'(i)}};
    store(14'h100, 3'd4, 4, 0);
    for (int i = 0; i < 4; i++) lbuf[i] = sbuf[i];
    for (int i = 0; i < 4; i++) sbuf[i] = {4{32'h90000000 + 32'(i)}};
    store(14'h100, 3'd4, 2, 0);
    rst = 1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1 rst = 0;
    @(negedge clk); check("midrst_release_req_ready", 128'(req_ready), 128'd1);
    lbuf[0] = sbuf[0]; lbuf[1] = sbuf[1];
    load(14'h100, 3'd4, 0);

    // Row wrap at the top of the banks.
    sbuf[0] = 128'hC0000003_C0000002_C0000001_C0000000;
    sbuf[1] = 128'hC1000003_C1000002_C1000001_C1000000;
    store(wrap_a, 3'd2, 4, 0);
    lbuf[0] = sbuf[0]; lbuf[1] = sbuf[1];
    load(wrap_a, 3'd2, 0);

    @(negedge clk);
    check("rd_q_drained", 128'(rd_q.size()), 128'd0);
    check("ev_q_drained", 128'(ev_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end
endmodule
